// File: rtl/anb_rd_if.sv
// ANB read channel: one addr/len request handshake plus the returned data burst.
interface anb_rd_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 16
);
    logic [ADDR_W-1:0] s_addr;
    logic [LEN_W-1:0]  s_len;
    logic              s_avalid;
    logic              s_aready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output s_addr, s_len, s_avalid, s_ready,
        input  s_aready, s_data, s_last, s_valid
    );

    modport slave (
        input  s_addr, s_len, s_avalid, s_ready,
        output s_aready, s_data, s_last, s_valid
    );
endinterface

// File: rtl/anb_rd_resp_m.sv
// ANB read responder: turns one addr/len request into RAM reads and returns the words
// as a burst; a credit counter bounds in-flight reads so the return FIFO never overflows.
module anb_rd_resp_m #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    anb_rd_if.slave           s,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                state_q;
    logic                  aready_q;
    logic [ADDR_W-1:0]     cur_q;
    logic [LEN_W-1:0]      rem_q;
    logic [CNT_W-1:0]      credit_q;
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [RD_LATENCY-1:0] pipe_last_q;
    logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
    logic                  fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;

    logic accept;
    logic issue;
    logic issue_last;
    logic push;
    logic pop;

    assign accept     = s.s_avalid & aready_q;
    assign issue      = (state_q == StIssue) && (rem_q != '0) && (credit_q != '0);
    assign issue_last = (rem_q == LEN_W'(1));
    assign push       = pipe_vld_q[RD_LATENCY-1];
    assign pop        = s.s_valid & s.s_ready;

    assign mem_re     = issue;
    assign mem_addr   = cur_q;
    assign busy       = (state_q != StIdle);
    assign s.s_aready = aready_q;
    assign s.s_valid  = (fifo_cnt_q != '0);
    assign s.s_data   = fifo_data_q[rd_ptr_q];
    assign s.s_last   = fifo_last_q[rd_ptr_q] & s.s_valid;

    // aready is held low through reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            aready_q <= 1'b0;
            cur_q    <= '0;
            rem_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    aready_q <= !accept;
                    if (accept) begin
                        cur_q   <= s.s_addr;
                        rem_q   <= (s.s_len == '0) ? LEN_W'(1) : s.s_len;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (issue) begin
                        cur_q <= cur_q + ADDR_W'(1);
                        rem_q <= rem_q - LEN_W'(1);
                        if (issue_last) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && s.s_last) begin
                        state_q  <= StIdle;
                        aready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Credit covers reads in the latency pipe plus words already buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= CNT_W'(FIFO_DEPTH);
        end else begin
            credit_q <= credit_q - CNT_W'(issue) + CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            for (int i = int'(RD_LATENCY) - 1; i > 0; i--) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue & issue_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_rdata;
                fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LATENCY-1];
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_anb_rd_resp_m.sv
// Bench for anb_rd_resp_m: RAM model, scoreboard of expected beats, directed vectors,
// hand-written latency/back-to-back/reset sequences and randomized requests.
module tb_anb_rd_resp_m;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned RD_LATENCY = 2;
    localparam int unsigned FIFO_DEPTH = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        bit                rnd_ready;
        int unsigned       beats;
        logic [ADDR_W-1:0] last_addr;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    anb_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    anb_rd_resp_m #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .RD_LATENCY(RD_LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (bus),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        if (a == 32'h10) return 64'hA5;
        return {a ^ 32'hC3A5_0F1E, ~a};
    endfunction

    // RAM: synchronous read, data RD_LATENCY cycles after the enable.
    logic [DATA_W-1:0] rd_pipe [RD_LATENCY];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_re ? ram_word(mem_addr) : '0;
        for (int i = 1; i < int'(RD_LATENCY); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LATENCY-1];

    bit rnd_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        bus.s_ready = rnd_ready ? ($urandom_range(0, 2) == 0) : 1'b1;
    end

    // Reference model: expected beats per accepted request and expected read addresses.
    beat_t             exp_q [$];
    int                outstanding = 0;
    int                inflight = 0;
    int                iss_left = 0;
    logic [ADDR_W-1:0] iss_next = '0;
    int                beats = 0;
    int                lasts = 0;
    logic [DATA_W-1:0] last_data = '0;
    int                cyc = 0;
    int                first_cyc = 0;
    int                last_cyc = 0;
    bit                hold_prev = 1'b0;
    logic [DATA_W-1:0] hold_data = '0;
    logic              hold_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            inflight    = 0;
            iss_left    = 0;
            hold_prev   = 1'b0;
        end else begin
            if (outstanding > 0) chk("aready_low_during_burst", bus.s_aready, 0);
            chk("busy", busy, outstanding > 0);
            if (hold_prev) begin
                chk("hold_valid", bus.s_valid, 1);
                chk("hold_data", bus.s_data, hold_data);
                chk("hold_last", bus.s_last, hold_last);
            end
            if (mem_re) begin
                chk("issue_expected", iss_left > 0, 1);
                chk("mem_addr", mem_addr, iss_next);
                iss_next = iss_next + 1;
                if (iss_left > 0) iss_left--;
                inflight++;
                chk("occupancy_bound", inflight <= int'(FIFO_DEPTH), 1);
            end
            if (bus.s_valid && bus.s_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("data", bus.s_data, e.data);
                    chk("last", bus.s_last, e.last);
                    if (e.last) outstanding--;
                end
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                inflight--;
                beats++;
                if (bus.s_last) begin
                    lasts++;
                    last_data = bus.s_data;
                end
            end
            if (bus.s_avalid && bus.s_aready) begin
                int n;
                n = (bus.s_len == 0) ? 1 : int'(bus.s_len);
                for (int i = 0; i < n; i++)
                    exp_q.push_back('{data: ram_word(bus.s_addr + ADDR_W'(i)), last: (i == n - 1)});
                outstanding++;
                iss_next = bus.s_addr;
                iss_left = n;
            end
            hold_prev = bus.s_valid && !bus.s_ready;
            hold_data = bus.s_data;
            hold_last = bus.s_last;
        end
    end

    task automatic clear_counts();
        beats = 0;
        lasts = 0;
        last_data = '0;
    endtask

    task automatic wait_aready();
        int n = 0;
        while (!bus.s_aready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("aready_timeout", bus.s_aready, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((outstanding != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", outstanding == 0, 1);
    endtask

    task automatic send_req(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        @(posedge clk);
        #1;
        wait_aready();
        clear_counts();
        bus.s_addr   = addr;
        bus.s_len    = len;
        bus.s_avalid = 1'b1;
        @(posedge clk);
        #1;
        bus.s_avalid = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{32'h0000_0020, 16'd0,  1'b0, 1,  32'h0000_0020};
        vecs[1] = '{32'h0000_0100, 16'd16, 1'b0, 16, 32'h0000_010F};
        vecs[2] = '{32'h0000_0040, 16'd32, 1'b1, 32, 32'h0000_005F};
        vecs[3] = '{32'hFFFF_FFFE, 16'd4,  1'b0, 4,  32'h0000_0001};
        vecs[4] = '{32'h0000_0007, 16'd3,  1'b1, 3,  32'h0000_0009};

        bus.s_addr   = '0;
        bus.s_len    = '0;
        bus.s_avalid = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_aready", bus.s_aready, 0);
        chk("rst_valid", bus.s_valid, 0);
        chk("rst_last", bus.s_last, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("aready_after_release", bus.s_aready, 1);

        // Single beat latency: accept at T, mem_re at T+1, data at T+2+RD_LATENCY.
        clear_counts();
        bus.s_addr   = 32'h10;
        bus.s_len    = 16'd1;
        bus.s_avalid = 1'b1;
        @(posedge clk);
        #1;
        bus.s_avalid = 1'b0;
        @(negedge clk);
        chk("t1_mem_re", mem_re, 1);
        @(negedge clk);
        chk("t2_valid", bus.s_valid, 0);
        @(negedge clk);
        chk("t3_valid", bus.s_valid, 0);
        @(negedge clk);
        chk("t4_valid", bus.s_valid, 1);
        chk("t4_data", bus.s_data, 64'hA5);
        chk("t4_last", bus.s_last, 1);
        wait_idle();
        chk("t1_beats", beats, 1);

        for (int v = 0; v < 5; v++) begin
            rnd_ready = vecs[v].rnd_ready;
            send_req(vecs[v].addr, vecs[v].len);
            wait_idle();
            chk("vec_beats", beats, vecs[v].beats);
            chk("vec_lasts", lasts, 1);
            chk("vec_last_data", last_data, ram_word(vecs[v].last_addr));
            if (!vecs[v].rnd_ready) chk("vec_contiguous", last_cyc - first_cyc, beats - 1);
        end
        rnd_ready = 1'b0;

        // Back-to-back requests with avalid held high.
        @(posedge clk);
        #1;
        wait_aready();
        clear_counts();
        bus.s_addr   = 32'h500;
        bus.s_len    = 16'd3;
        bus.s_avalid = 1'b1;
        @(posedge clk);
        #1;
        bus.s_addr = 32'h600;
        bus.s_len  = 16'd2;
        begin
            int n = 0;
            while (!bus.s_aready && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("b2b_second_accept", bus.s_aready, 1);
        @(posedge clk);
        #1;
        bus.s_avalid = 1'b0;
        wait_idle();
        chk("b2b_beats", beats, 5);
        chk("b2b_lasts", lasts, 2);

        // Reset in the middle of a len=8 burst after 3 beats.
        send_req(32'h300, 16'd8);
        begin
            int n = 0;
            while (beats < 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("mid_three_beats", beats, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.s_valid, 0);
        chk("mid_rst_last", bus.s_last, 0);
        chk("mid_rst_data", bus.s_data, 0);
        chk("mid_rst_mem_re", mem_re, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_aready", bus.s_aready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_aready_after_release", bus.s_aready, 1);
        send_req(32'h400, 16'd2);
        wait_idle();
        chk("post_rst_beats", beats, 2);
        chk("post_rst_lasts", lasts, 1);
        chk("post_rst_last_data", last_data, ram_word(32'h401));

        // Randomized requests against the scoreboard.
        for (int r = 0; r < 8; r++) begin
            logic [ADDR_W-1:0] a;
            logic [LEN_W-1:0]  l;
            a = $urandom;
            l = LEN_W'($urandom_range(0, 40));
            rnd_ready = ($urandom_range(0, 1) == 1);
            send_req(a, l);
            wait_idle();
            chk("rnd_beats", beats, (l == 0) ? 1 : int'(l));
            chk("rnd_lasts", lasts, 1);
        end
        rnd_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("final_no_valid", bus.s_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
